// File: rtl/regfile.sv
// Two-read, one-write register file; x0 has no storage and always reads zero.
// Reads are combinational (zero latency), writes land on the rising edge; no backpressure.
module regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write,
    input  logic [AW-1:0]   writenum,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   readnum1,
    input  logic [AW-1:0]   readnum2,
    output logic [XLEN-1:0] data_out1,
    output logic [XLEN-1:0] data_out2
);

    logic [XLEN-1:0] regs [1:NREGS-1];

    // Reset wins over a same-edge write; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write && (writenum != '0)) begin
            regs[writenum] <= write_data;
        end
    end

    // No write-to-read bypass: a port shows the old value until the edge.
    assign data_out1 = (readnum1 == '0) ? '0 : regs[readnum1];
    assign data_out2 = (readnum2 == '0) ? '0 : regs[readnum2];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            write;
    logic [4:0]      writenum;
    logic [XLEN-1:0] write_data;
    logic [4:0]      readnum1;
    logic [4:0]      readnum2;
    logic [XLEN-1:0] data_out1;
    logic [XLEN-1:0] data_out2;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] model [NREGS];

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .writenum   (writenum),
        .write_data (write_data),
        .readnum1   (readnum1),
        .readnum2   (readnum2),
        .data_out1  (data_out1),
        .data_out2  (data_out2)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of architectural registers.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else if (write) begin
            model[writenum] = write_data;
        end
    end

    function automatic logic [XLEN-1:0] ref_read(input logic [4:0] idx);
        return (idx == 5'd0) ? '0 : model[idx];
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            readnum1 = 5'(i);
            readnum2 = 5'(NREGS - 1 - i);
            #1;
            check({tag, "_p1"}, data_out1, '0);
            check({tag, "_p2"}, data_out2, '0);
        end
    endtask

    initial begin
        logic [5:0] wide_idx;

        // Reset with a write pending: write must be discarded.
        rst_n      = 1'b0;
        write      = 1'b1;
        writenum   = 5'd3;
        write_data = 64'd99;
        readnum1   = 5'd0;
        readnum2   = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // x1 = 42
        rst_n      = 1'b1;
        write      = 1'b1;
        writenum   = 5'd1;
        write_data = 64'd42;
        readnum1   = 5'd1;
        readnum2   = 5'd0;
        @(posedge clk); #1;
        check("x1_write", data_out1, 64'd42);
        check("x0_read", data_out2, 64'd0);

        // x2 = 84, dual read
        @(negedge clk);
        writenum   = 5'd2;
        write_data = 64'd84;
        @(posedge clk); #1;
        write    = 1'b0;
        readnum1 = 5'd1;
        readnum2 = 5'd2;
        #1;
        check("dual_p1", data_out1, 64'd42);
        check("dual_p2", data_out2, 64'd84);

        // Write to x0 is ignored
        @(negedge clk);
        write      = 1'b1;
        writenum   = 5'd0;
        write_data = 64'd100;
        readnum1   = 5'd0;
        readnum2   = 5'd1;
        @(posedge clk); #1;
        write = 1'b0;
        check("x0_ignored", data_out1, 64'd0);
        check("x1_kept", data_out2, 64'd42);

        // Index 32 truncates to 0
        wide_idx = 6'd32;
        readnum1 = wide_idx[4:0];
        readnum2 = wide_idx[4:0];
        #1;
        check("trunc_p1", data_out1, 64'd0);
        check("trunc_p2", data_out2, 64'd0);

        // Old value before edge, new after, no bypass
        @(negedge clk);
        readnum1   = 5'd5;
        readnum2   = 5'd5;
        write      = 1'b1;
        writenum   = 5'd5;
        write_data = 64'hDEADBEEFCAFEF00D;
        #1;
        check("x5_before_edge", data_out1, 64'd0);
        @(posedge clk); #1;
        check("x5_after_edge", data_out1, 64'hDEADBEEFCAFEF00D);
        check("x5_same_idx_p2", data_out2, 64'hDEADBEEFCAFEF00D);
        @(negedge clk);
        write      = 1'b0;
        write_data = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        check("x5_no_write", data_out1, 64'hDEADBEEFCAFEF00D);

        // Load x3, then reset with simultaneous write x3=7
        @(negedge clk);
        write      = 1'b1;
        writenum   = 5'd3;
        write_data = 64'd55;
        readnum1   = 5'd3;
        @(posedge clk); #1;
        check("x3_loaded", data_out1, 64'd55);
        @(negedge clk);
        rst_n      = 1'b0;
        write_data = 64'd7;
        @(posedge clk); #1;
        rst_n = 1'b1;
        write = 1'b0;
        check_all_zero("midreset");

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(63) != 0);
            write      = $urandom_range(3) != 0;
            writenum   = 5'($urandom_range(NREGS - 1));
            write_data = {$urandom, $urandom};
            readnum1   = 5'($urandom_range(NREGS - 1));
            readnum2   = ($urandom_range(7) == 0) ? readnum1 : 5'($urandom_range(NREGS - 1));
            #1;
            check("rand_p1", data_out1, ref_read(readnum1));
            check("rand_p2", data_out2, ref_read(readnum2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
